traffic_light_monitor: RTL and testbench

// - Receive-side checker for the 4-lamp junction light bus (M1, Mt, M2, S) driven by the traffic controller.
// - Decodes each lamp's 3-bit colour, tracks per-lamp phase and dwell time, and detects safety and sequence faults.
// - Latches the first fault as sticky for the supervisor until it is cleared. Also counts completed junction cycles.

---
 rtl/traffic_pkg.sv | 53 +++++
 rtl/lamp_tracker.sv | 89 ++++++++
 rtl/traffic_light_monitor.sv | 143 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction light bus monitor.
package traffic_pkg;

    // Lamp colour encoding on the bus (one-hot).
    typedef enum logic [2:0] {
        COL_RED = 3'b100,
        COL_YEL = 3'b010,
        COL_GRN = 3'b001
    } colour_e;

    // Per-lamp tracker phase.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RED  = 2'd1,
        ST_YEL  = 2'd2,
        ST_GRN  = 2'd3
    } lamp_state_e;

    // Fault codes, lowest value has highest priority.
    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_ONEHOT   = 3'd1,
        FLT_CONFLICT = 3'd2,
        FLT_SEQ      = 3'd3,
        FLT_DWELL    = 3'd4,
        FLT_STUCK    = 3'd5
    } fault_e;

    localparam int NUM_LAMPS = 4;

    localparam logic [1:0] LAMP_M1 = 2'd0;
    localparam logic [1:0] LAMP_MT = 2'd1;
    localparam logic [1:0] LAMP_M2 = 2'd2;
    localparam logic [1:0] LAMP_S  = 2'd3;

    // Only GRN->YEL, YEL->RED and RED->GRN are allowed colour changes.
    function automatic logic legal_step(input lamp_state_e from_st, input lamp_state_e to_st);
        return ((from_st == ST_GRN) && (to_st == ST_YEL)) ||
               ((from_st == ST_YEL) && (to_st == ST_RED)) ||
               ((from_st == ST_RED) && (to_st == ST_GRN));
    endfunction

    // Index of the lowest set bit; lower lamp index wins on ties.
    function automatic logic [1:0] lowest_lamp(input logic [NUM_LAMPS-1:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_LAMPS - 1; i >= 0; i--) begin
            if (vec[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lamp_tracker.sv
// Tracks one lamp's phase and dwell time and flags per-lamp faults.
module lamp_tracker
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int GREEN_MIN  = 2,
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 3,
    parameter int STUCK_MAX  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [2:0]       lamp,
    output lamp_state_e      state,
    output logic [CNT_W-1:0] dwell,
    output logic             onehot_err,
    output logic             seq_err,
    output logic             dwell_err,
    output logic             stuck_err,
    output logic             yel_to_red
);

    localparam logic [CNT_W-1:0] DWELL_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DWELL_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] YEL_LIM    = CNT_W'(YELLOW_MIN);
    localparam logic [CNT_W-1:0] YEL_OVER   = CNT_W'(YELLOW_MAX + 1);
    localparam logic [CNT_W-1:0] STUCK_LIM  = CNT_W'(STUCK_MAX);

    lamp_state_e      state_reg, state_next;
    logic [CNT_W-1:0] dwell_reg, dwell_next;
    lamp_state_e      sample_st;

    assign state = state_reg;
    assign dwell = dwell_reg;

    // Phase and dwell registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_INIT;
            dwell_reg <= '0;
        end else begin
            state_reg <= state_next;
            dwell_reg <= dwell_next;
        end
    end

    // Decode the sample, compare it with the held phase and raise per-lamp faults.
    // Dwell checks use the count of samples already seen in the current colour.
    always_comb begin
        state_next = state_reg;
        dwell_next = dwell_reg;
        onehot_err = 1'b0;
        seq_err    = 1'b0;
        dwell_err  = 1'b0;
        stuck_err  = 1'b0;
        yel_to_red = 1'b0;
        case (lamp)
            COL_RED: sample_st = ST_RED;
            COL_YEL: sample_st = ST_YEL;
            COL_GRN: sample_st = ST_GRN;
            default: sample_st = ST_INIT;
        endcase

        if (sample_valid) begin
            if (sample_st == ST_INIT) begin
                onehot_err = 1'b1;
                state_next = ST_INIT;
                dwell_next = '0;
            end else if (state_reg == ST_INIT) begin
                state_next = sample_st;
                dwell_next = DWELL_ONE;
            end else if (sample_st == state_reg) begin
                if (dwell_reg != DWELL_SAT) dwell_next = dwell_reg + DWELL_ONE;
                stuck_err = (dwell_reg == STUCK_LIM);
                dwell_err = (state_reg == ST_YEL) && (dwell_reg == YEL_OVER);
            end else begin
                state_next = sample_st;
                dwell_next = DWELL_ONE;
                seq_err    = !legal_step(state_reg, sample_st);
                dwell_err  = ((state_reg == ST_GRN) && (dwell_reg < GREEN_LIM)) ||
                             ((state_reg == ST_YEL) && (dwell_reg < YEL_LIM));
                yel_to_red = (state_reg == ST_YEL) && (sample_st == ST_RED);
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the 4-lamp junction light bus: sticky first fault and cycle count.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int GREEN_MIN  = 2,
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 3,
    parameter int STUCK_MAX  = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_Mt,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_lamp,
    output logic [7:0] cycle_count
);

    logic [2:0]           lamp_in  [NUM_LAMPS];
    logic [2:0]           lamp_reg [NUM_LAMPS];
    // The cleared input register holds 000, which is not a legal colour; checks
    // stay off until the first real sample has been captured after reset.
    logic                 valid_reg;

    lamp_state_e          trk_state [NUM_LAMPS];
    logic [CNT_W-1:0]     trk_dwell [NUM_LAMPS];
    logic [NUM_LAMPS-1:0] onehot_vec, seq_vec, dwell_vec, stuck_vec, y2r_vec, non_red;
    logic [NUM_LAMPS-1:0] unused_trk;

    logic                 conflict;
    fault_e               det_code;
    logic [1:0]           det_lamp;

    logic                 fault_reg;
    fault_e               fault_code_reg;
    logic [1:0]           fault_lamp_reg;
    logic [7:0]           cycle_count_reg;

    assign lamp_in[LAMP_M1] = light_M1;
    assign lamp_in[LAMP_MT] = light_Mt;
    assign lamp_in[LAMP_M2] = light_M2;
    assign lamp_in[LAMP_S]  = light_S;

    // Sample-valid flag for the input stage.
    always_ff @(posedge clk) begin
        if (!rst) valid_reg <= 1'b0;
        else      valid_reg <= 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAMPS; gi++) begin : g_lamp
            // Input stage: capture the lamp every cycle.
            always_ff @(posedge clk) begin
                if (!rst) lamp_reg[gi] <= 3'b000;
                else      lamp_reg[gi] <= lamp_in[gi];
            end

            lamp_tracker #(
                .CNT_W      (CNT_W),
                .GREEN_MIN  (GREEN_MIN),
                .YELLOW_MIN (YELLOW_MIN),
                .YELLOW_MAX (YELLOW_MAX),
                .STUCK_MAX  (STUCK_MAX)
            ) u_trk (
                .clk          (clk),
                .rst          (rst),
                .sample_valid (valid_reg),
                .lamp         (lamp_reg[gi]),
                .state        (trk_state[gi]),
                .dwell        (trk_dwell[gi]),
                .onehot_err   (onehot_vec[gi]),
                .seq_err      (seq_vec[gi]),
                .dwell_err    (dwell_vec[gi]),
                .stuck_err    (stuck_vec[gi]),
                .yel_to_red   (y2r_vec[gi])
            );

            assign non_red[gi]    = (lamp_reg[gi] != COL_RED);
            assign unused_trk[gi] = ^{trk_state[gi], trk_dwell[gi]};
        end
    endgenerate

    // Side road may only show non-red while all main lamps are red; Mt and M2 are mutually exclusive.
    assign conflict = valid_reg &&
        ((non_red[LAMP_S] && (non_red[LAMP_M1] || non_red[LAMP_MT] || non_red[LAMP_M2])) ||
         (non_red[LAMP_MT] && non_red[LAMP_M2]));

    // Priority encoder: lowest fault code first, then lowest lamp index.
    always_comb begin
        det_code = FLT_NONE;
        det_lamp = 2'd0;
        if (|onehot_vec) begin
            det_code = FLT_ONEHOT;
            det_lamp = lowest_lamp(onehot_vec);
        end else if (conflict) begin
            det_code = FLT_CONFLICT;
        end else if (|seq_vec) begin
            det_code = FLT_SEQ;
            det_lamp = lowest_lamp(seq_vec);
        end else if (|dwell_vec) begin
            det_code = FLT_DWELL;
            det_lamp = lowest_lamp(dwell_vec);
        end else if (|stuck_vec) begin
            det_code = FLT_STUCK;
            det_lamp = lowest_lamp(stuck_vec);
        end
    end

    // Sticky fault latch; a detection in the clearing cycle takes the slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_reg      <= 1'b0;
            fault_code_reg <= FLT_NONE;
            fault_lamp_reg <= 2'd0;
        end else if ((det_code != FLT_NONE) && (!fault_reg || fault_clr)) begin
            fault_reg      <= 1'b1;
            fault_code_reg <= det_code;
            fault_lamp_reg <= det_lamp;
        end else if (fault_clr) begin
            fault_reg      <= 1'b0;
            fault_code_reg <= FLT_NONE;
            fault_lamp_reg <= 2'd0;
        end
    end

    // Junction cycle counter: one count per legal side-road yellow-to-red.
    always_ff @(posedge clk) begin
        if (!rst)                  cycle_count_reg <= 8'd0;
        else if (y2r_vec[LAMP_S])  cycle_count_reg <= cycle_count_reg + 8'd1;
    end

    assign fault       = fault_reg;
    assign fault_code  = fault_code_reg;
    assign fault_lamp  = fault_lamp_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] light_M1 = R, light_Mt = R, light_M2 = R, light_S = R;
    logic       fault_clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_lamp;
    logic [7:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    traffic_light_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .light_M1    (light_M1),
        .light_Mt    (light_Mt),
        .light_M2    (light_M2),
        .light_S     (light_S),
        .fault_clr   (fault_clr),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_lamp  (fault_lamp),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample to all four lamps, then step past the next rising edge.
    task automatic drive(input logic [2:0] m1, input logic [2:0] mt,
                         input logic [2:0] m2, input logic [2:0] s);
        light_M1 = m1;
        light_Mt = mt;
        light_M2 = m2;
        light_S  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b0;
        fault_clr = 1'b0;
        drive(R, R, R, R);
        check_val({tag, "_rst_fault"}, 32'(fault), 0);
        check_val({tag, "_rst_code"},  32'(fault_code), 0);
        check_val({tag, "_rst_lamp"},  32'(fault_lamp), 0);
        check_val({tag, "_rst_count"}, 32'(cycle_count), 0);
        drive(R, R, R, R);
        rst = 1'b1;
    endtask

    // Each lamp in turn: 3 green, 2 yellow, red otherwise; 20 samples per junction cycle.
    function automatic logic [2:0] phase_col(input int lamp, input int t);
        if (t >= 5 * lamp && t < 5 * lamp + 3) return G;
        if (t >= 5 * lamp + 3 && t < 5 * lamp + 5) return Y;
        return R;
    endfunction

    initial begin
        // Test 1: three legal junction cycles.
        do_reset("t1");
        drive(R, R, R, R);
        drive(R, R, R, R);
        for (int c = 0; c < 3; c++) begin
            for (int t = 0; t < 20; t++) begin
                drive(phase_col(0, t), phase_col(1, t), phase_col(2, t), phase_col(3, t));
                check_val("t1_fault", 32'(fault), 0);
                if (c > 0 && t == 1) check_val("t1_count_mid", 32'(cycle_count), 32'(c));
            end
        end
        drive(R, R, R, R);
        drive(R, R, R, R);
        check_val("t1_count", 32'(cycle_count), 3);
        check_val("t1_fault_end", 32'(fault), 0);
        $display("t1 legal cycles: count=%0d fault=%0d", cycle_count, fault);

        // Test 2: invalid colour on M1 (mid-run reset also clears the count of 3).
        do_reset("t2");
        drive(R, R, R, R);
        drive(R, R, R, R);
        drive(3'b011, R, R, R);
        check_val("t2_latency", 32'(fault), 0);
        drive(R, R, R, R);
        check_val("t2_fault", 32'(fault), 1);
        check_val("t2_code", 32'(fault_code), 1);
        check_val("t2_lamp", 32'(fault_lamp), 0);
        $display("t2 onehot: fault=%0d code=%0d lamp=%0d", fault, fault_code, fault_lamp);

        // Test 3: side road green with M1 green, then a later SEQ is ignored.
        do_reset("t3");
        drive(R, R, R, R);
        drive(R, R, R, R);
        drive(G, R, R, G);
        drive(G, R, R, G);
        check_val("t3_fault", 32'(fault), 1);
        check_val("t3_code", 32'(fault_code), 2);
        check_val("t3_lamp", 32'(fault_lamp), 0);
        drive(R, R, R, R);
        drive(R, R, R, R);
        drive(R, R, R, R);
        check_val("t3_code_held", 32'(fault_code), 2);
        check_val("t3_lamp_held", 32'(fault_lamp), 0);
        $display("t3 conflict: code=%0d lamp=%0d", fault_code, fault_lamp);

        // Test 4: M2 green straight to red, then clear.
        do_reset("t4");
        drive(R, R, R, R);
        drive(R, R, R, R);
        for (int k = 0; k < 3; k++) drive(R, R, G, R);
        drive(R, R, R, R);
        drive(R, R, R, R);
        check_val("t4_fault", 32'(fault), 1);
        check_val("t4_code", 32'(fault_code), 3);
        check_val("t4_lamp", 32'(fault_lamp), 2);
        fault_clr = 1'b1;
        drive(R, R, R, R);
        fault_clr = 1'b0;
        check_val("t4_clr", 32'(fault), 0);
        $display("t4 seq+clear: fault=%0d", fault);

        // Test 5: Mt yellow held for 5 samples.
        do_reset("t5");
        drive(R, R, R, R);
        drive(R, R, R, R);
        for (int k = 0; k < 3; k++) drive(R, G, R, R);
        for (int k = 0; k < 5; k++) drive(R, Y, R, R);
        check_val("t5_early", 32'(fault), 0);
        drive(R, R, R, R);
        check_val("t5_fault", 32'(fault), 1);
        check_val("t5_code", 32'(fault_code), 4);
        check_val("t5_lamp", 32'(fault_lamp), 1);
        $display("t5 yellow overstay: code=%0d lamp=%0d", fault_code, fault_lamp);

        // Test 6: all lamps stuck red, clear racing a new fault, reset mid-run.
        do_reset("t6");
        for (int k = 0; k < 25; k++) drive(R, R, R, R);
        check_val("t6_early", 32'(fault), 0);
        drive(R, R, R, R);
        check_val("t6_fault", 32'(fault), 1);
        check_val("t6_code", 32'(fault_code), 5);
        check_val("t6_lamp", 32'(fault_lamp), 0);
        drive(3'b011, R, R, R);
        fault_clr = 1'b1;
        drive(R, R, R, R);
        fault_clr = 1'b0;
        check_val("t6_race_fault", 32'(fault), 1);
        check_val("t6_race_code", 32'(fault_code), 1);
        $display("t6 stuck+race: fault=%0d code=%0d", fault, fault_code);

        // Test 7: reset with a fault held; first post-reset colour is not sequence-checked.
        do_reset("t7");
        drive(Y, R, R, R);
        drive(Y, R, R, R);
        drive(R, R, R, R);
        check_val("t7_no_seq", 32'(fault), 0);
        $display("t7 post-reset: fault=%0d", fault);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
